fpu_arbiter: RTL
================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 The block SHALL have parameter NX, default 8: exponent width of operands.
REQ-003 The block SHALL have parameter NM, default 23: mantissa width; W = 1+NX+NM.
REQ-004 The block SHALL have parameter TIMEOUT, default 64: WAIT-cycle limit, used only with FPU_ARB_TIMEOUT_EN.
REQ-005 The block SHALL have port CLK  in  1  sole clock, rising edge.
REQ-006 The block SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port REQ_VALID  in  NREQ  per-requester request.
REQ-008 The block SHALL have port REQ_OP  in  2*NREQ  per-requester op (ADD, SUB, MUL, DIV).
REQ-009 The block SHALL have port REQ_A, REQ_B  in  W*NREQ  per-requester operands, IEEE754 packed.
REQ-010 The block SHALL have port REQ_READY  out  NREQ  one-hot accept pulse.
REQ-011 The block SHALL have port RSP_VALID  out  NREQ  one-hot response pulse.
REQ-012 The block SHALL have port RSP_DATA  out  W  shared result bus.
REQ-013 The block SHALL have port FPU_VALID  out  1  issue pulse to shared FPU.
REQ-014 The block SHALL have ports FPU_OP  out  2, FPU_A and FPU_B  out  W: held operands.
REQ-015 The block SHALL have ports FPU_DONE  in  1 and FPU_RES  in  W: FPU completion.
REQ-016 The block SHALL have port BUSY  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: if any REQ_VALID is high, the block SHALL grant g, the first set bit searching upward from pointer PTR with wrap; it SHALL assert REQ_READY[g] that cycle, capture REQ_OP/A/B[g], and go to ISSUE.
REQ-019 ISSUE: the block SHALL assert FPU_VALID for exactly one cycle and go to WAIT; FPU_OP/A/B SHALL hold the captured values from ISSUE through WAIT.
REQ-020 WAIT: on FPU_DONE the block SHALL capture FPU_RES and go to RESP; FPU_DONE in any other state SHALL be ignored.
REQ-021 RESP: the block SHALL assert RSP_VALID[g] for one cycle with RSP_DATA equal to the captured result, set PTR = (g+1) mod NREQ, and go to IDLE.
REQ-022 RSP_DATA SHALL hold its last value outside RESP.
REQ-023 Latency from the REQ_READY cycle to the RSP_VALID cycle SHALL be L+2 cycles, where L is the number of cycles FPU_DONE arrives after FPU_VALID (L>=1).
REQ-024 Only one operation SHALL be in flight; REQ_READY SHALL be low in all non-IDLE states.
REQ-025 A requester deasserting REQ_VALID before being granted SHALL simply not be granted; no state is kept per requester.
REQ-026 Round-robin SHALL guarantee that each continuously requesting requester is served within NREQ grants.

Reset
REQ-027 While RST_N is low, the block SHALL set state to IDLE, PTR to 0, and all outputs (REQ_READY, RSP_VALID, RSP_DATA, FPU_VALID, FPU_OP/A/B, BUSY, ERR) to 0.
REQ-028 Reset asserted mid-operation SHALL abort it; a late FPU_DONE after reset SHALL be ignored and produce no response.

Configuration
REQ-029 With FPU_ARB_TIMEOUT_EN defined, a WAIT counter SHALL run; after TIMEOUT cycles without FPU_DONE the block SHALL enter RESP with RSP_DATA = canonical quiet NaN (sign 0, exp all ones, mant MSB 1, rest 0) and pulse output ERR (1 bit) for that cycle.
REQ-030 Without FPU_ARB_TIMEOUT_EN, WAIT SHALL last indefinitely, and the block SHALL have no ERR port and no counter.

Structure
REQ-031 Package fp SHALL hold the op enum (ADD=0, SUB=1, MUL=2, DIV=3) and the canonical NaN function of NX, NM; the operand type SHALL use the IEEE754(NX, NM) macro.
REQ-032 Sub-module rr_arbiter (NREQ request bits plus PTR, producing a one-hot grant and a valid flag) SHALL be instantiated once.

Verification
REQ-033 Bench: single request from requester 2, MUL 3.0*2.0, FPU L=4 -> REQ_READY[2] pulses, FPU_VALID one cycle later, RSP_VALID[2] 6 cycles after REQ_READY, RSP_DATA=0x40C00000.
REQ-034 Bench: all 4 REQ_VALID held high after reset -> grant order 0,1,2,3,0.
REQ-035 Bench: PTR=3, requests 1 and 3 -> requester 3 served first, then requester 1.
REQ-036 Bench: RST_N low during WAIT, then FPU_DONE asserted -> no RSP_VALID, all outputs 0, next grant starts from 0.
REQ-037 Bench: with FPU_ARB_TIMEOUT_EN and TIMEOUT=8, FPU_DONE never asserted -> RESP after 8 WAIT cycles, RSP_DATA=0x7FC00000, ERR pulses once.
REQ-038 Bench: FPU_DONE pulsed while IDLE -> no state change, no RSP_VALID.

Source files
------------

// File: rtl/fpu_arbiter_pkg.sv
// Shared definitions for fpu_arbiter: op encoding, FSM states, IEEE754 packed operand macro, canonical NaN.
// The optional WAIT timeout in fpu_arbiter is enabled by defining FPU_ARB_TIMEOUT_EN.
`ifndef FPU_ARB_IEEE754_DEFINED
`define FPU_ARB_IEEE754_DEFINED
`define IEEE754(nx, nm) struct packed { logic sign; logic [(nx)-1:0] exp; logic [(nm)-1:0] mant; }
`endif

package fp;
   typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, DIV = 2'd3} fpu_op_e;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

   localparam int MAX_W = 64;

   // Quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
   function automatic logic [MAX_W-1:0] canonical_nan(input int nx, input int nm);
      logic [MAX_W-1:0] r;
      r = ((MAX_W'(1) << nx) - MAX_W'(1)) << nm;
      r = r | (MAX_W'(1) << (nm - 1));
      return r;
   endfunction
endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// Round-robin request picker: grants the first set request at or above ptr, wrapping past NREQ-1.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant,
   output logic                    valid
);
   localparam int PW = $clog2(NREQ);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
         idx = sum[PW-1:0];
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fpu_arbiter.sv
// Shares one FPU among NREQ requesters, one operation in flight, round-robin fairness.
// Define FPU_ARB_TIMEOUT_EN to bound WAIT by TIMEOUT cycles (answers with a quiet NaN and pulses ERR).
module fpu_arbiter
   import fp::*;
#(
   parameter  int NREQ    = 4,
   parameter  int NX      = 8,
   parameter  int NM      = 23,
   parameter  int TIMEOUT = 64,
   localparam int W       = 1 + NX + NM
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [NREQ-1:0]   REQ_VALID,
   input  logic [2*NREQ-1:0] REQ_OP,
   input  logic [W*NREQ-1:0] REQ_A,
   input  logic [W*NREQ-1:0] REQ_B,
   output logic [NREQ-1:0]   REQ_READY,
   output logic [NREQ-1:0]   RSP_VALID,
   output logic [W-1:0]      RSP_DATA,
   output logic              FPU_VALID,
   output logic [1:0]        FPU_OP,
   output logic [W-1:0]      FPU_A,
   output logic [W-1:0]      FPU_B,
   input  logic              FPU_DONE,
   input  logic [W-1:0]      FPU_RES,
   output logic              BUSY,
`ifdef FPU_ARB_TIMEOUT_EN
   output logic              ERR,
`endif
   output arb_state_e        DBG_STATE
);
   localparam int PW = $clog2(NREQ);

   typedef `IEEE754(NX, NM) operand_t;

   // Handshake: REQ_READY[g] is a one-cycle accept while IDLE; the requester's op/operands are taken
   // that cycle. FPU_VALID pulses once per op; FPU_DONE counts only in WAIT; RSP_VALID[g] pulses once.
   arb_state_e      state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   gidx_q, gidx_d;
   fpu_op_e         op_q, op_d;
   operand_t        a_q, a_d, b_q, b_d;
   logic [W-1:0]    rsp_data_q, rsp_data_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic            fpu_valid_q, fpu_valid_d;
   logic            busy_q, busy_d;

   logic [NREQ-1:0] grant;
   logic            grant_valid;
   logic [PW-1:0]   grant_idx;

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int          CW   = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] QNAN = W'(canonical_nan(NX, NM));
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          err_q, err_d;
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT;
`endif

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (REQ_VALID),
      .ptr   (ptr_q),
      .grant (grant),
      .valid (grant_valid)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (grant[i]) grant_idx = PW'(i);
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      rsp_data_d = rsp_data_q;
`ifdef FPU_ARB_TIMEOUT_EN
      err_d      = 1'b0;
      wait_cnt_d = (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
`endif
      unique case (state_q)
         IDLE: if (grant_valid) begin
            gidx_d  = grant_idx;
            op_d    = fpu_op_e'(REQ_OP[2*int'(grant_idx) +: 2]);
            a_d     = operand_t'(REQ_A[W*int'(grant_idx) +: W]);
            b_d     = operand_t'(REQ_B[W*int'(grant_idx) +: W]);
            state_d = ISSUE;
         end
         ISSUE: state_d = WAIT;
         WAIT: if (FPU_DONE) begin
            rsp_data_d = FPU_RES;
            state_d    = RESP;
         end
`ifdef FPU_ARB_TIMEOUT_EN
         else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_data_d = QNAN;
            err_d      = 1'b1;
            state_d    = RESP;
         end
`endif
         RESP: begin
            ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
            state_d = IDLE;
         end
      endcase
      fpu_valid_d = (state_d == ISSUE);
      busy_d      = (state_d != IDLE);
      rsp_valid_d = (state_d == RESP) ? (NREQ'(1) << gidx_d) : '0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gidx_q      <= '0;
         op_q        <= ADD;
         a_q         <= '0;
         b_q         <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= '0;
         fpu_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gidx_q      <= gidx_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
         fpu_valid_q <= fpu_valid_d;
         busy_q      <= busy_d;
`ifdef FPU_ARB_TIMEOUT_EN
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   // The accept is combinational on REQ_VALID, so it is also held off while reset is asserted.
   assign REQ_READY = (state_q == IDLE && RST_N) ? grant : '0;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA  = rsp_data_q;
   assign FPU_VALID = fpu_valid_q;
   assign FPU_OP    = op_q;
   assign FPU_A     = a_q;
   assign FPU_B     = b_q;
   assign BUSY      = busy_q;
   assign DBG_STATE = state_q;
`ifdef FPU_ARB_TIMEOUT_EN
   assign ERR       = err_q;
`endif
endmodule
